// File: rtl/jkr_cport_dpkt_mem_param_pkg.sv
// Shared constants, types and state encoding for the control-port data-packet memory.
// Used by the ingress write initiator and its parity generator.
package jkr_cport_dpkt_mem_param_pkg;

    localparam int INGRESS_ADDR_WIDTH = 10;
    localparam int INGRESS_DATA_WIDTH = 512;
    localparam int WORD_WIDTH         = 32;
    localparam int WORDS_PER_LINE     = INGRESS_DATA_WIDTH / WORD_WIDTH;

    typedef logic [INGRESS_ADDR_WIDTH-1:0] ingress_addr_t;
    typedef logic [INGRESS_DATA_WIDTH-1:0] ingress_data_t;
    typedef logic [WORDS_PER_LINE-1:0]     ingress_data_parity_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SEND
    } dpkt_ingress_wr_state_e;

endpackage

// File: rtl/jkr_cport_dpkt_parity_gen.sv
// Chunk-wise odd-parity generator: parity[c] makes chunk c plus its parity bit odd.
// Purely combinational; callers feed it registered values.
module jkr_cport_dpkt_parity_gen #(
    parameter int CHUNK_W  = 32,
    parameter int N_CHUNKS = 16
) (
    input  logic [CHUNK_W*N_CHUNKS-1:0] i_data,
    output logic [N_CHUNKS-1:0]         o_parity
);

    always_comb begin
        o_parity = '0;
        for (int c = 0; c < N_CHUNKS; c++) begin
            o_parity[c] = ~^i_data[c*CHUNK_W +: CHUNK_W];
        end
    end

endmodule

// File: rtl/jkr_cport_dpkt_ingress_wr.sv
// Ingress write initiator: packs 16 stream words per 512-bit line and writes each line
// with odd data/address parity over a valid/ack handshake. Optional parity error
// injection is enabled by defining JKR_CPORT_DPKT_INGRESS_ERR_INJ_EN.
module jkr_cport_dpkt_ingress_wr #(
    parameter int INGRESS_ADDR_WIDTH = jkr_cport_dpkt_mem_param_pkg::INGRESS_ADDR_WIDTH,
    parameter int INGRESS_DATA_WIDTH = jkr_cport_dpkt_mem_param_pkg::INGRESS_DATA_WIDTH,
    parameter int WORD_WIDTH         = jkr_cport_dpkt_mem_param_pkg::WORD_WIDTH
) (
    input  logic                                     i_core_clk,
    input  logic                                     i_reset,
    input  logic                                     i_start,
    input  logic [INGRESS_ADDR_WIDTH-1:0]            i_base_addr,
    input  logic                                     i_word_valid,
    output logic                                     o_word_ready,
    input  logic [WORD_WIDTH-1:0]                    i_word_data,
    input  logic                                     i_word_last,
    output logic                                     o_wr_valid,
    output logic [INGRESS_ADDR_WIDTH-1:0]            o_core_addr,
    output logic [INGRESS_DATA_WIDTH-1:0]            o_data,
    output logic [INGRESS_DATA_WIDTH/WORD_WIDTH-1:0] o_data_parity,
    output logic                                     o_addr_parity,
`ifdef JKR_CPORT_DPKT_INGRESS_ERR_INJ_EN
    input  logic [INGRESS_DATA_WIDTH/WORD_WIDTH-1:0] i_inj_data_par_err,
    input  logic                                     i_inj_addr_par_err,
`endif
    input  logic                                     i_wr_ack,
    output logic                                     o_busy,
    output logic                                     o_pkt_done
);

    import jkr_cport_dpkt_mem_param_pkg::*;

    localparam int NUM_WORDS = INGRESS_DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    dpkt_ingress_wr_state_e state_q, state_d;
    logic [INGRESS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INGRESS_DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          last_q, last_d;
    logic                          pkt_done_q, pkt_done_d;
    logic [NUM_WORDS-1:0]          inj_data_q;
    logic                          inj_addr_q;
    logic [NUM_WORDS-1:0]          data_par_raw;
    logic [0:0]                    addr_par_raw;

`ifdef JKR_CPORT_DPKT_INGRESS_ERR_INJ_EN
    logic [NUM_WORDS-1:0] inj_data_d;
    logic                 inj_addr_d;
`else
    assign inj_data_q = '0;
    assign inj_addr_q = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        last_d     = last_q;
        pkt_done_d = 1'b0;
`ifdef JKR_CPORT_DPKT_INGRESS_ERR_INJ_EN
        inj_data_d = inj_data_q;
        inj_addr_d = inj_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    idx_d   = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (i_word_valid) begin
                    data_d[idx_q*WORD_WIDTH +: WORD_WIDTH] = i_word_data;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NUM_WORDS - 1) || i_word_last) begin
                        last_d  = i_word_last;
                        state_d = ST_SEND;
`ifdef JKR_CPORT_DPKT_INGRESS_ERR_INJ_EN
                        inj_data_d = i_inj_data_par_err;
                        inj_addr_d = i_inj_addr_par_err;
`endif
                    end
                end
            end
            ST_SEND: begin
                if (i_wr_ack) begin
`ifdef JKR_CPORT_DPKT_INGRESS_ERR_INJ_EN
                    // Injected errors apply to the line just acknowledged only.
                    inj_data_d = '0;
                    inj_addr_d = 1'b0;
`endif
                    if (last_q) begin
                        pkt_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        idx_d   = '0;
                        data_d  = '0;
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the line buffer is reset because it drives o_data directly and must read zero.
    always_ff @(posedge i_core_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            pkt_done_q <= pkt_done_d;
        end
    end

`ifdef JKR_CPORT_DPKT_INGRESS_ERR_INJ_EN
    always_ff @(posedge i_core_clk or posedge i_reset) begin
        if (i_reset) begin
            inj_data_q <= '0;
            inj_addr_q <= 1'b0;
        end else begin
            inj_data_q <= inj_data_d;
            inj_addr_q <= inj_addr_d;
        end
    end
`endif

    jkr_cport_dpkt_parity_gen #(
        .CHUNK_W  (WORD_WIDTH),
        .N_CHUNKS (NUM_WORDS)
    ) u_data_par (
        .i_data   (data_q),
        .o_parity (data_par_raw)
    );

    jkr_cport_dpkt_parity_gen #(
        .CHUNK_W  (INGRESS_ADDR_WIDTH),
        .N_CHUNKS (1)
    ) u_addr_par (
        .i_data   (addr_q),
        .o_parity (addr_par_raw)
    );

    // Outputs decode flops only; no input reaches an output combinationally.
    assign o_word_ready  = (state_q == ST_FILL);
    assign o_wr_valid    = (state_q == ST_SEND);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_core_addr   = addr_q;
    assign o_data        = data_q;
    assign o_data_parity = data_par_raw ^ inj_data_q;
    assign o_addr_parity = addr_par_raw[0] ^ inj_addr_q;
    assign o_pkt_done    = pkt_done_q;

endmodule
